lfsr_sequence_generator: RTL and testbench

Parametrised pseudo-random symbol sequence source for N-button Simon-style games. A free-running LFSR supplies the seeds. A second LFSR replays a deterministic sequence from the captured seed. The block also tracks the current round length and the replay position, so the game FSM only issues randomize / start_over / next / extend strobes and reads back one-hot symbols and status flags.

---
 rtl/lfsr_sequence_generator_if.sv | 31 +++
 rtl/lfsr_sequence_generator.sv | 103 ++++++++++
 tb/tb_lfsr_sequence_generator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lfsr_sequence_generator_if.sv
// Control/status bundle between a Simon-style game FSM and its
// pseudo-random symbol sequence source.
interface lfsr_sequence_generator_if #(
    parameter int NUM_SYMBOLS = 2,
    parameter int SYM_BITS    = 1,
    parameter int LEN_BITS    = 8
);
    // Strobes issued by the game FSM
    logic                   randomize_seed;
    logic                   start_over;
    logic                   next;
    logic                   extend;

    // Symbol and round status returned by the generator
    logic [NUM_SYMBOLS-1:0] seq;
    logic [SYM_BITS-1:0]    sym_idx;
    logic [LEN_BITS-1:0]    pos;
    logic [LEN_BITS-1:0]    length;
    logic                   last;
    logic                   full;

    modport master (
        output randomize_seed, start_over, next, extend,
        input  seq, sym_idx, pos, length, last, full
    );

    modport slave (
        input  randomize_seed, start_over, next, extend,
        output seq, sym_idx, pos, length, last, full
    );
endinterface

// File: rtl/lfsr_sequence_generator.sv
// Pseudo-random symbol sequence source for N-button Simon-style games.
// A free-running LFSR provides seeds; a second LFSR replays a deterministic
// sequence from the captured seed while round length and replay position
// are tracked here so the game FSM only issues strobes.
module lfsr_sequence_generator #(
    parameter int                    LFSR_WIDTH  = 18,
    parameter logic [LFSR_WIDTH-1:0] TAPS        = 18'h20400,
    parameter logic [LFSR_WIDTH-1:0] INIT        = 18'h26AD7,
    parameter int                    NUM_SYMBOLS = 2,
    parameter int                    SYM_BITS    = 1,
    parameter int                    MAX_LEN     = 32,
    parameter int                    LEN_BITS    = 8
) (
    input logic                      clk,
    input logic                      rst,
    lfsr_sequence_generator_if.slave bus
);

    localparam logic [LEN_BITS-1:0] MAX_LEN_V = LEN_BITS'(MAX_LEN);
    localparam logic [LEN_BITS-1:0] ONE_V     = LEN_BITS'(1);
    localparam logic [SYM_BITS:0]   NUM_SYM_V = (SYM_BITS + 1)'(NUM_SYMBOLS);

    logic [LFSR_WIDTH-1:0] counter;
    logic [LFSR_WIDTH-1:0] seed;
    logic [LFSR_WIDTH-1:0] current;
    logic [LEN_BITS-1:0]   pos;
    logic [LEN_BITS-1:0]   length;
    logic                  last;
    logic                  full;
    logic [SYM_BITS-1:0]   raw;
    logic [SYM_BITS-1:0]   sym_idx;

    // One Fibonacci step: shift left, feedback is the parity of tapped bits.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] state);
        return {state[LFSR_WIDTH-2:0], ^(state & TAPS)};
    endfunction

    // Advance by SYM_BITS steps so every symbol is built from fresh bits.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_advance(input logic [LFSR_WIDTH-1:0] state);
        logic [LFSR_WIDTH-1:0] s;
        s = state;
        for (int i = 0; i < SYM_BITS; i++) begin
            s = lfsr_step(s);
        end
        return s;
    endfunction

    // Free-running seed source; steps every cycle so the seed depends on when the player acts.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= INIT;
        end else begin
            counter <= lfsr_step(counter);
        end
    end

    // Seed capture; an all-zero counter would lock the replay LFSR, so INIT is substituted.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed <= INIT;
        end else if (bus.randomize_seed) begin
            seed <= (counter == '0) ? INIT : counter;
        end
    end

    // Replay state and position; start_over reads the pre-update seed, so a same-cycle randomize only affects later restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            current <= INIT;
            pos     <= '0;
        end else if (bus.start_over) begin
            current <= seed;
            pos     <= '0;
        end else if (bus.next && !last) begin
            current <= lfsr_advance(current);
            pos     <= pos + ONE_V;
        end
    end

    // Round length grows by one per extend and holds once the maximum is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            length <= ONE_V;
        end else if (bus.extend && !full) begin
            length <= length + ONE_V;
        end
    end

    assign last = (pos == length - ONE_V);
    assign full = (length == MAX_LEN_V);

    // Out-of-range raw codes fold back into range by subtracting NUM_SYMBOLS.
    assign raw     = current[SYM_BITS-1:0];
    assign sym_idx = ({1'b0, raw} >= NUM_SYM_V) ? raw - SYM_BITS'(NUM_SYMBOLS) : raw;

    assign bus.sym_idx = sym_idx;
    assign bus.seq     = NUM_SYMBOLS'(1) << sym_idx;
    assign bus.pos     = pos;
    assign bus.length  = length;
    assign bus.last    = last;
    assign bus.full    = full;

endmodule

// File: tb/tb_lfsr_sequence_generator.sv
// Directed self-checking bench for lfsr_sequence_generator: a default
// two-symbol instance plus two three-symbol instances whose INIT values
// force the symbol fold-back paths.
module tb_lfsr_sequence_generator;

    localparam logic [17:0] TAPS   = 18'h20400;
    localparam logic [17:0] INIT_A = 18'h26AD7;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [17:0] m_counter;
    logic [17:0] m_cur;
    logic [17:0] exp_seed1;
    logic [17:0] exp_seed2;
    logic [0:0]  stream [0:3];
    int          bad;
    int          nexts;

    lfsr_sequence_generator_if #(.NUM_SYMBOLS(2), .SYM_BITS(1), .LEN_BITS(8)) if_a ();
    lfsr_sequence_generator_if #(.NUM_SYMBOLS(3), .SYM_BITS(2), .LEN_BITS(8)) if_b ();
    lfsr_sequence_generator_if #(.NUM_SYMBOLS(3), .SYM_BITS(2), .LEN_BITS(8)) if_c ();

    lfsr_sequence_generator dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

    lfsr_sequence_generator #(
        .INIT(18'h00003), .NUM_SYMBOLS(3), .SYM_BITS(2)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    lfsr_sequence_generator #(
        .INIT(18'h00002), .NUM_SYMBOLS(3), .SYM_BITS(2)
    ) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    always #5 clk = ~clk;

    function automatic logic [17:0] step(input logic [17:0] s);
        return {s[16:0], ^(s & TAPS)};
    endfunction

    // Reference copy of the free-running counter of dut_a.
    always @(posedge clk) begin
        if (rst) m_counter <= INIT_A;
        else     m_counter <= step(m_counter);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {if_a.randomize_seed, if_a.start_over, if_a.next, if_a.extend} = '0;
        {if_b.randomize_seed, if_b.start_over, if_b.next, if_b.extend} = '0;
        {if_c.randomize_seed, if_c.start_over, if_c.next, if_c.extend} = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_output("rst_current", 32'(dut_a.current), 32'h26AD7);
        check_output("rst_seed",    32'(dut_a.seed),    32'h26AD7);
        check_output("rst_seq",     32'(if_a.seq),      32'h2);
        check_output("rst_sym",     32'(if_a.sym_idx),  32'h1);
        check_output("rst_pos",     32'(if_a.pos),      32'h0);
        check_output("rst_length",  32'(if_a.length),   32'h1);
        check_output("rst_last",    32'(if_a.last),     32'h1);
        check_output("rst_full",    32'(if_a.full),     32'h0);

        // Fold-back: raw 3 -> symbol 0, raw 2 -> symbol 2
        check_output("b_sym_wrap", 32'(if_b.sym_idx), 32'h0);
        check_output("b_seq_wrap", 32'(if_b.seq),     32'h1);
        check_output("c_sym_two",  32'(if_c.sym_idx), 32'h2);
        check_output("c_seq_two",  32'(if_c.seq),     32'h4);

        // extend once then next; a second next at last is ignored
        if_a.extend = 1'b1; tick(); if_a.extend = 1'b0;
        check_output("ext_length", 32'(if_a.length), 32'h2);
        check_output("ext_last",   32'(if_a.last),   32'h0);
        if_a.next = 1'b1; tick(); if_a.next = 1'b0;
        check_output("nxt_current", 32'(dut_a.current), 32'h0D5AF);
        check_output("nxt_seq",     32'(if_a.seq),      32'h2);
        check_output("nxt_pos",     32'(if_a.pos),      32'h1);
        check_output("nxt_last",    32'(if_a.last),     32'h1);
        if_a.next = 1'b1; tick(); if_a.next = 1'b0;
        check_output("ign_current", 32'(dut_a.current), 32'h0D5AF);
        check_output("ign_pos",     32'(if_a.pos),      32'h1);

        // Grow to length 4, then randomize and replay twice
        if_a.extend = 1'b1; tick(); tick(); if_a.extend = 1'b0;
        check_output("len4", 32'(if_a.length), 32'h4);
        exp_seed1 = m_counter;
        if_a.randomize_seed = 1'b1; tick(); if_a.randomize_seed = 1'b0;
        check_output("rnd_seed", 32'(dut_a.seed), 32'(exp_seed1));
        if_a.start_over = 1'b1; tick(); if_a.start_over = 1'b0;
        check_output("so_current", 32'(dut_a.current), 32'(exp_seed1));
        check_output("so_pos",     32'(if_a.pos),      32'h0);
        m_cur = exp_seed1;
        stream[0] = if_a.sym_idx;
        check_output("p1_sym0", 32'(if_a.sym_idx), 32'(m_cur[0]));
        for (int i = 1; i < 4; i++) begin
            if_a.next = 1'b1; tick(); if_a.next = 1'b0;
            m_cur = step(m_cur);
            stream[i] = if_a.sym_idx;
            check_output("p1_current", 32'(dut_a.current), 32'(m_cur));
            check_output("p1_sym",     32'(if_a.sym_idx),  32'(m_cur[0]));
        end
        check_output("p1_last", 32'(if_a.last), 32'h1);
        if_a.start_over = 1'b1; tick(); if_a.start_over = 1'b0;
        check_output("p2_sym0", 32'(if_a.sym_idx), 32'(stream[0]));
        for (int i = 1; i < 4; i++) begin
            if_a.next = 1'b1; tick(); if_a.next = 1'b0;
            check_output("p2_sym", 32'(if_a.sym_idx), 32'(stream[i]));
        end

        // Same-cycle randomize + start_over loads the old seed
        exp_seed2 = m_counter;
        if_a.randomize_seed = 1'b1; if_a.start_over = 1'b1; tick();
        if_a.randomize_seed = 1'b0; if_a.start_over = 1'b0;
        check_output("both_current", 32'(dut_a.current), 32'(exp_seed1));
        check_output("both_seed",    32'(dut_a.seed),    32'(exp_seed2));
        check_output("both_pos",     32'(if_a.pos),      32'h0);
        if_a.start_over = 1'b1; tick(); if_a.start_over = 1'b0;
        check_output("new_current", 32'(dut_a.current), 32'(exp_seed2));

        // Three-symbol instance: symbols must stay in range over 1000 nexts
        if_b.extend = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        if_b.extend = 1'b0;
        check_output("b_length", 32'(if_b.length), 32'd32);
        check_output("b_full",   32'(if_b.full),   32'h1);
        bad   = 0;
        nexts = 0;
        while (nexts < 1000) begin
            if (if_b.last) begin
                if_b.start_over = 1'b1;
                if_b.randomize_seed = 1'b1;
            end else begin
                if_b.next = 1'b1;
                nexts++;
            end
            tick();
            {if_b.randomize_seed, if_b.start_over, if_b.next} = '0;
            if (if_b.sym_idx >= 2'd3 || if_b.seq !== (3'b001 << if_b.sym_idx)) bad++;
        end
        check_output("b_range", 32'(bad), 32'h0);

        // Saturating length and a full-length replay
        if_a.extend = 1'b1;
        for (int i = 0; i < 35; i++) tick();
        if_a.extend = 1'b0;
        check_output("sat_length", 32'(if_a.length), 32'd32);
        check_output("sat_full",   32'(if_a.full),   32'h1);
        if_a.start_over = 1'b1; tick(); if_a.start_over = 1'b0;
        m_cur = exp_seed2;
        check_output("full_last0", 32'(if_a.last), 32'h0);
        for (int i = 0; i < 31; i++) begin
            if_a.next = 1'b1; tick(); if_a.next = 1'b0;
            m_cur = step(m_cur);
        end
        check_output("full_pos",     32'(if_a.pos),      32'd31);
        check_output("full_last",    32'(if_a.last),     32'h1);
        check_output("full_current", 32'(dut_a.current), 32'(m_cur));
        check_output("full_sym",     32'(if_a.sym_idx),  32'(m_cur[0]));
        if_a.next = 1'b1; if_a.extend = 1'b1; tick();
        if_a.next = 1'b0; if_a.extend = 1'b0;
        check_output("full_hold_pos", 32'(if_a.pos),    32'd31);
        check_output("full_hold_len", 32'(if_a.length), 32'd32);

        // Reset mid-round returns to the post-reset state
        if_a.next = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        if_a.next = 1'b0;
        check_output("mid_pos",     32'(if_a.pos),      32'h0);
        check_output("mid_length",  32'(if_a.length),   32'h1);
        check_output("mid_current", 32'(dut_a.current), 32'h26AD7);
        check_output("mid_seed",    32'(dut_a.seed),    32'h26AD7);
        check_output("mid_full",    32'(if_a.full),     32'h0);
        check_output("mid_last",    32'(if_a.last),     32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
